// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, recoded multiples
// and the iteration-count helper.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } booth_mult_t;

    // Two extension bits plus two multiplier bits retired per iteration.
    function automatic int booth_iter(input int width);
        return (width + 2) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: maps a multiplier triplet to the signed multiple of the
// extended multiplicand, sized one bit wider than X so that +-2X fits.
module booth_r4_recode
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       trip,
    input  logic [WIDTH+1:0] xext,
    output logic [WIDTH+2:0] mult
);

    booth_mult_t      sel;
    logic [WIDTH+2:0] x1;
    logic [WIDTH+2:0] x2;

    assign x1 = {xext[WIDTH+1], xext};
    assign x2 = {xext, 1'b0};

    always_comb begin
        sel = ZERO;
        case (trip)
            3'b001, 3'b010: sel = P1;
            3'b011:         sel = P2;
            3'b100:         sel = M2;
            3'b101, 3'b110: sel = M1;
            default:        sel = ZERO;
        endcase
    end

    always_comb begin
        mult = '0;
        case (sel)
            P1:      mult = x1;
            P2:      mult = x2;
            M1:      mult = -x1;
            M2:      mult = -x2;
            default: mult = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier with valid/ready on operands and result.
// Optional BOOTH_R4_MUL_ZERO_SKIP_EN: a zero operand goes straight to DONE with z=0.
module booth_r4_mul
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ITER  = booth_iter(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               tc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z,
    output logic               busy
);

    localparam int XW = WIDTH + 2;
    localparam int AW = WIDTH + 3;
    localparam int CW = $clog2(ITER + 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CALC = CALC;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]    state;
    logic [XW-1:0] xq;
    logic [AW-1:0] acc;
    logic [AW-1:0] mq;
    logic [CW-1:0] cnt;

    logic [XW-1:0]   x_ext;
    logic [XW-1:0]   y_ext;
    logic [AW-1:0]   mult;
    logic [AW-1:0]   sum;
    logic [2*AW-1:0] shifted;
    logic            last;

    assign x_ext = tc ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
    assign y_ext = tc ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};

    booth_r4_recode #(.WIDTH(WIDTH)) u_recode (
        .trip (mq[2:0]),
        .xext (xq),
        .mult (mult)
    );

    // The appended zero below Y sits at mq[0]; after ITER double-shifts the
    // product's LSB has landed at bit 1 of the combined register.
    always_comb begin
        sum     = acc + mult;
        shifted = $signed({sum, mq}) >>> 2;
        last    = (cnt == CW'(ITER - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            z     <= '0;
            cnt   <= '0;
            acc   <= '0;
            mq    <= '0;
            xq    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        xq  <= x_ext;
                        mq  <= {y_ext, 1'b0};
                        acc <= '0;
                        cnt <= '0;
`ifdef BOOTH_R4_MUL_ZERO_SKIP_EN
                        if (x == '0 || y == '0) begin
                            state <= S_DONE;
                            z     <= '0;
                        end else begin
                            state <= S_CALC;
                        end
`else
                        state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    acc <= shifted[2*AW-1:AW];
                    mq  <= shifted[AW-1:0];
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= S_DONE;
                        z     <= shifted[2*WIDTH:1];
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_CALC);

endmodule
